bsg_manycore_mmio_responder: RTL and testbench
==============================================

Name: bsg_manycore_mmio_responder

Overview:
- Network-side endpoint that services the request packets the host IO endpoint injects into the manycore, and returns one response packet per request.
- Owns a small word-addressed register/scratch memory.
- Decodes load, store and atomic-add operations and keeps request/error statistics.
- Sits on the manycore side of the host link; the host endpoint is the initiator, this block is the responder.

Parameters:
- addr_width_p, 28, word address width of incoming requests
- data_width_p, 32, data word width (multiple of 8)
- x_cord_width_p, 7, source/destination X coordinate width
- y_cord_width_p, 7, source/destination Y coordinate width
- reg_id_width_p, 5, request tag width echoed in the response
- mem_els_p, 64, words of local memory (power of two, >=2)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- req_v_i  in  1  request valid
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o
- req_op_i  in  2  0 load, 1 store, 2 amoadd, 3 reserved
- req_addr_i  in  addr_width_p  word address
- req_data_i  in  data_width_p  store/amo operand
- req_mask_i  in  data_width_p/8  byte write mask (store only)
- req_src_x_i  in  x_cord_width_p  requester X
- req_src_y_i  in  y_cord_width_p  requester Y
- req_reg_id_i  in  reg_id_width_p  request tag
- resp_v_o  out  1  response valid
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i
- resp_type_o  out  2  0 load data, 1 store ack, 2 amo data, 3 error
- resp_data_o  out  data_width_p  response payload
- resp_reg_id_o  out  reg_id_width_p  echoed tag
- resp_dst_x_o  out  x_cord_width_p  = captured req_src_x_i
- resp_dst_y_o  out  y_cord_width_p  = captured req_src_y_i
- req_count_o  out  32  completed requests, wraps at 2^32
- err_count_o  out  16  error responses, saturates at 0xFFFF

Behaviour:
- Clocking: single clock domain. reset_i is asynchronous and active-high; every flop except the memory array clears immediately on assertion.
- Reset values:
  - state IDLE
  - req_ready_o=1 once reset deasserts (it is 0 while reset_i is high)
  - resp_v_o=0
  - all resp_* payload outputs 0
  - req_count_o=0, err_count_o=0
- Memory contents are not reset and are undefined until written.
- FSM states IDLE, EXEC, RESP. One request in flight; no pipelining.
  - IDLE: req_ready_o=1. On handshake, capture op, addr, data, mask, src_x, src_y and reg_id, then go to EXEC. With no handshake, stay in IDLE.
  - EXEC: req_ready_o=0. Exactly one cycle. Decode, perform the memory action, register the response fields, then go to RESP.
  - RESP: resp_v_o=1 and the payload is held stable until resp_ready_i. On the handshake edge: resp_v_o drops to 0, req_count_o increments (plus err_count_o if the type is error), and the state returns to IDLE.
- No combinational path from resp_ready_i to req_ready_o. A new request can be accepted only in the cycle after the response handshake.
- Latency:
  - Request accepted at edge N; resp_v_o rises after edge N+1.
  - With resp_ready_i tied high, the minimum request-to-request period is 3 cycles.
- Address decode: index = addr[log2(mem_els_p)-1:0]. The access is in range iff all higher address bits are 0.
- Load: resp_type 0, data = mem[index].
- Store: each byte b with mask[b]=1 is written with data byte b; other bytes are unchanged. Mask 0 writes nothing but still acks. resp_type 1, data 0.
- Amoadd:
  - mem[index] <= mem[index] + operand, modulo 2^data_width_p (carry discarded).
  - resp_type 2, data = the old value.
  - Mask is ignored.
- Error cases: out-of-range address, or op 3. No memory change, resp_type 3, data 0.
- Memory is written only on the EXEC edge and is read combinationally from the flop array during EXEC.
- Inputs are sampled only on the handshake edge; changes while the FSM is busy are ignored.
- Reset mid-operation (EXEC or RESP): the FSM returns to IDLE, the pending response is discarded and not counted, and resp_v_o drops asynchronously. A memory write completed at an earlier EXEC edge persists.

Test Plan:
- Reset; store addr 5, data 0xDEADBEEF, mask 0xF, reg_id 3, src (2,1); then load addr 5 -> store ack type 1 with reg_id 3 to dst (2,1); load returns type 0, data 0xDEADBEEF; resp_v_o rises 2 cycles after accept; req_count_o=2.
- Store 0x11223344 mask 0xF to addr 7, then store 0xAABBCCDD mask 0x5 to addr 7, then load addr 7 -> 0x11BB33DD.
- mem[9]=0xFFFFFFFF; amoadd addr 9 with operand 2; then load addr 9 -> amo response type 2, data 0xFFFFFFFF; load returns 0x00000001.
- Load addr 64 and op 3 to addr 0 (mem_els_p=64) -> both respond type 3, data 0; memory unchanged; err_count_o=2.
- Hold resp_ready_i low for 10 cycles with req_v_i asserted and changing payload -> resp_v_o and payload stable, req_ready_o=0, no second accept; after release, the next accept occurs exactly 1 cycle later.
- Assert reset_i while in RESP -> resp_v_o falls without a clock edge; counters 0; after deassert, a load of the previously stored address returns the stored data.

Source files
------------

// File: rtl/bsg_manycore_mmio_responder_if.sv
// Request/response handshake bundle between the host IO endpoint (master)
// and the manycore-side MMIO responder (slave).
interface bsg_manycore_mmio_responder_if #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int reg_id_width_p = 5
) ();

  logic                        req_v_i;
  logic                        req_ready_o;
  logic [1:0]                  req_op_i;
  logic [addr_width_p-1:0]     req_addr_i;
  logic [data_width_p-1:0]     req_data_i;
  logic [data_width_p/8-1:0]   req_mask_i;
  logic [x_cord_width_p-1:0]   req_src_x_i;
  logic [y_cord_width_p-1:0]   req_src_y_i;
  logic [reg_id_width_p-1:0]   req_reg_id_i;

  logic                        resp_v_o;
  logic                        resp_ready_i;
  logic [1:0]                  resp_type_o;
  logic [data_width_p-1:0]     resp_data_o;
  logic [reg_id_width_p-1:0]   resp_reg_id_o;
  logic [x_cord_width_p-1:0]   resp_dst_x_o;
  logic [y_cord_width_p-1:0]   resp_dst_y_o;

  modport slave (
    input  req_v_i, req_op_i, req_addr_i, req_data_i, req_mask_i,
           req_src_x_i, req_src_y_i, req_reg_id_i, resp_ready_i,
    output req_ready_o, resp_v_o, resp_type_o, resp_data_o,
           resp_reg_id_o, resp_dst_x_o, resp_dst_y_o
  );

  modport master (
    output req_v_i, req_op_i, req_addr_i, req_data_i, req_mask_i,
           req_src_x_i, req_src_y_i, req_reg_id_i, resp_ready_i,
    input  req_ready_o, resp_v_o, resp_type_o, resp_data_o,
           resp_reg_id_o, resp_dst_x_o, resp_dst_y_o
  );

endinterface

// File: rtl/bsg_manycore_mmio_responder.sv
// Manycore-side MMIO endpoint: word scratch memory serving load/store/amoadd
// requests one at a time, with one response per request plus statistics.
//
// state | meaning
// IDLE  | ready for a request; captures fields on handshake
// EXEC  | single cycle: decode, memory read/write, register response
// RESP  | response held valid until consumed
module bsg_manycore_mmio_responder #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int reg_id_width_p = 5,
  parameter int mem_els_p      = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bsg_manycore_mmio_responder_if.slave  bus,
  output logic [31:0]                   req_count_o,
  output logic [15:0]                   err_count_o
);

  localparam int lg_els_lp     = $clog2(mem_els_p);
  localparam int mask_width_lp = data_width_p / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  op_q;
  logic [addr_width_p-1:0]     addr_q;
  logic [data_width_p-1:0]     data_q;
  logic [mask_width_lp-1:0]    mask_q;
  logic [x_cord_width_p-1:0]   src_x_q;
  logic [y_cord_width_p-1:0]   src_y_q;
  logic [reg_id_width_p-1:0]   reg_id_q;
  logic [1:0]                  resp_type_q, resp_type_d;
  logic [data_width_p-1:0]     resp_data_q, resp_data_d;
  logic [31:0]                 req_count_q;
  logic [15:0]                 err_count_q;

  logic [data_width_p-1:0]     mem_q [mem_els_p];
  logic [lg_els_lp-1:0]        idx;
  logic                        in_range;
  logic [data_width_p-1:0]     mem_rd;
  logic [data_width_p-1:0]     mem_wdata;
  logic                        mem_we;
  logic                        req_hs;
  logic                        resp_hs;

  // Ready depends only on state and reset, never on resp_ready_i.
  assign bus.req_ready_o = (state_q == IDLE) & ~reset_i;
  assign req_hs          = bus.req_v_i & bus.req_ready_o;
  assign resp_hs         = (state_q == RESP) & bus.resp_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      src_x_q  <= '0;
      src_y_q  <= '0;
      reg_id_q <= '0;
    end else if (req_hs) begin
      op_q     <= bus.req_op_i;
      addr_q   <= bus.req_addr_i;
      data_q   <= bus.req_data_i;
      mask_q   <= bus.req_mask_i;
      src_x_q  <= bus.req_src_x_i;
      src_y_q  <= bus.req_src_y_i;
      reg_id_q <= bus.req_reg_id_i;
    end
  end

  assign idx      = addr_q[lg_els_lp-1:0];
  assign in_range = (addr_q[addr_width_p-1:lg_els_lp] == '0);
  assign mem_rd   = mem_q[idx];

  always_comb begin
    resp_type_d = 2'd3;
    resp_data_d = '0;
    mem_we      = 1'b0;
    mem_wdata   = mem_rd;
    if (in_range) begin
      case (op_q)
        2'd0: begin
          resp_type_d = 2'd0;
          resp_data_d = mem_rd;
        end
        2'd1: begin
          resp_type_d = 2'd1;
          mem_we      = (state_q == EXEC);
          for (int b = 0; b < mask_width_lp; b++) begin
            if (mask_q[b]) mem_wdata[8*b +: 8] = data_q[8*b +: 8];
          end
        end
        2'd2: begin
          resp_type_d = 2'd2;
          resp_data_d = mem_rd;
          mem_we      = (state_q == EXEC);
          mem_wdata   = mem_rd + data_q;
        end
        default: begin
          resp_type_d = 2'd3;
          resp_data_d = '0;
        end
      endcase
    end
  end

  // Scratch memory is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx] <= mem_wdata;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_type_q <= '0;
      resp_data_q <= '0;
    end else if (state_q == EXEC) begin
      resp_type_q <= resp_type_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_count_q <= '0;
      err_count_q <= '0;
    end else if (resp_hs) begin
      req_count_q <= req_count_q + 32'd1;
      if (resp_type_q == 2'd3 && err_count_q != 16'hFFFF)
        err_count_q <= err_count_q + 16'd1;
    end
  end

  assign bus.resp_v_o      = (state_q == RESP);
  assign bus.resp_type_o   = resp_type_q;
  assign bus.resp_data_o   = resp_data_q;
  assign bus.resp_reg_id_o = reg_id_q;
  assign bus.resp_dst_x_o  = src_x_q;
  assign bus.resp_dst_y_o  = src_y_q;
  assign req_count_o       = req_count_q;
  assign err_count_o       = err_count_q;

endmodule

// File: tb/tb_bsg_manycore_mmio_responder.sv
// Bench for the MMIO responder: directed vector table, stall and reset
// sequences, then random traffic against a word-array reference model.
module tb_bsg_manycore_mmio_responder;

  logic        clk;
  logic        rst;
  logic [31:0] req_count;
  logic [15:0] err_count;

  bsg_manycore_mmio_responder_if bus ();

  bsg_manycore_mmio_responder dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .bus         (bus),
    .req_count_o (req_count),
    .err_count_o (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [64];
  logic [31:0] exp_req = 0;
  logic [15:0] exp_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [4:0]  tag;
    logic [6:0]  sx;
    logic [6:0]  sy;
    logic [1:0]  et;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference semantics: words indexed by address, anything >= 64 or op 3 is an error.
  function automatic void ref_exec(input logic [1:0] op, input logic [27:0] addr,
                                   input logic [31:0] data, input logic [3:0] mask,
                                   output logic [1:0] t, output logic [31:0] d);
    logic [31:0] bm;
    int a;
    a = int'(addr);
    t = 2'd3;
    d = 32'd0;
    if (op != 2'd3 && addr < 28'd64) begin
      if (op == 2'd0) begin
        t = 2'd0;
        d = model_mem[a];
      end else if (op == 2'd1) begin
        bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        model_mem[a] = (model_mem[a] & ~bm) | (data & bm);
        t = 2'd1;
      end else begin
        t = 2'd2;
        d = model_mem[a];
        model_mem[a] = model_mem[a] + data;
      end
    end
  endfunction

  task automatic drive_req(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [6:0] sx, input logic [6:0] sy,
                           input logic [4:0] tag);
    bus.req_v_i      = 1'b1;
    bus.req_op_i     = op;
    bus.req_addr_i   = addr;
    bus.req_data_i   = data;
    bus.req_mask_i   = mask;
    bus.req_src_x_i  = sx;
    bus.req_src_y_i  = sy;
    bus.req_reg_id_i = tag;
  endtask

  task automatic issue(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [6:0] sx, input logic [6:0] sy,
                       input logic [4:0] tag, input logic [1:0] et, input logic [31:0] ed);
    int n;
    @(negedge clk);
    drive_req(op, addr, data, mask, sx, sy, tag);
    n = 0;
    while (!bus.req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.req_v_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_v_i = 1'b0;
    check("exec_resp_v_low", 64'(bus.resp_v_o), 64'd0);
    check("exec_ready_low", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    check("resp_v_latency", 64'(bus.resp_v_o), 64'd1);
    check("resp_type", 64'(bus.resp_type_o), 64'(et));
    check("resp_data", 64'(bus.resp_data_o), 64'(ed));
    check("resp_reg_id", 64'(bus.resp_reg_id_o), 64'(tag));
    check("resp_dst_x", 64'(bus.resp_dst_x_o), 64'(sx));
    check("resp_dst_y", 64'(bus.resp_dst_y_o), 64'(sy));
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    exp_req = exp_req + 32'd1;
    if (et == 2'd3 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    check("resp_v_drop", 64'(bus.resp_v_o), 64'd0);
    check("ready_after_resp", 64'(bus.req_ready_o), 64'd1);
    check("req_count", 64'(req_count), 64'(exp_req));
    check("err_count", 64'(err_count), 64'(exp_err));
  endtask

  initial begin
    logic [1:0]  t;
    logic [31:0] d;
    logic [1:0]  op;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;

    tbl[0]  = '{2'd1, 28'd5,  32'hDEADBEEF, 4'hF, 5'd3,  7'd2, 7'd1, 2'd1, 32'h0};
    tbl[1]  = '{2'd0, 28'd5,  32'h0,        4'h0, 5'd4,  7'd2, 7'd1, 2'd0, 32'hDEADBEEF};
    tbl[2]  = '{2'd1, 28'd7,  32'h11223344, 4'hF, 5'd5,  7'd3, 7'd0, 2'd1, 32'h0};
    tbl[3]  = '{2'd1, 28'd7,  32'hAABBCCDD, 4'h5, 5'd6,  7'd3, 7'd0, 2'd1, 32'h0};
    tbl[4]  = '{2'd0, 28'd7,  32'h0,        4'hF, 5'd7,  7'd3, 7'd0, 2'd0, 32'h11BB33DD};
    tbl[5]  = '{2'd1, 28'd9,  32'hFFFFFFFF, 4'hF, 5'd8,  7'd1, 7'd5, 2'd1, 32'h0};
    tbl[6]  = '{2'd2, 28'd9,  32'h2,        4'hF, 5'd9,  7'd1, 7'd5, 2'd2, 32'hFFFFFFFF};
    tbl[7]  = '{2'd0, 28'd9,  32'h0,        4'h0, 5'd10, 7'd1, 7'd5, 2'd0, 32'h00000001};
    tbl[8]  = '{2'd1, 28'd0,  32'h12345678, 4'hF, 5'd11, 7'd0, 7'd0, 2'd1, 32'h0};
    tbl[9]  = '{2'd0, 28'd64, 32'h0,        4'hF, 5'd12, 7'd9, 7'd9, 2'd3, 32'h0};
    tbl[10] = '{2'd3, 28'd0,  32'hFFFF,     4'hF, 5'd13, 7'd9, 7'd8, 2'd3, 32'h0};
    tbl[11] = '{2'd0, 28'd0,  32'h0,        4'h0, 5'd14, 7'd4, 7'd4, 2'd0, 32'h12345678};
    tbl[12] = '{2'd1, 28'd5,  32'h0,        4'h0, 5'd15, 7'd6, 7'd2, 2'd1, 32'h0};
    tbl[13] = '{2'd0, 28'd5,  32'h0,        4'h0, 5'd16, 7'd6, 7'd2, 2'd0, 32'hDEADBEEF};
    tbl[14] = '{2'd2, 28'd9,  32'hFFFFFFFF, 4'h0, 5'd17, 7'd7, 7'd3, 2'd2, 32'h00000001};
    tbl[15] = '{2'd0, 28'd9,  32'h0,        4'h0, 5'd18, 7'd7, 7'd3, 2'd0, 32'h0};

    bus.req_v_i = 1'b0;
    bus.resp_ready_i = 1'b0;
    drive_req(2'd0, 28'd0, 32'd0, 4'd0, 7'd0, 7'd0, 5'd0);
    bus.req_v_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.req_ready_o), 64'd0);
    check("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
    check("rst_resp_type", 64'(bus.resp_type_o), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data_o), 64'd0);
    check("rst_resp_tag", 64'(bus.resp_reg_id_o), 64'd0);
    check("rst_req_count", 64'(req_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(bus.req_ready_o), 64'd1);

    for (int i = 0; i < 16; i++) begin
      ref_exec(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask, t, d);
      issue(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask,
            tbl[i].sx, tbl[i].sy, tbl[i].tag, tbl[i].et, tbl[i].ed);
    end
    check("table_err_count", 64'(err_count), 64'd2);

    // Response stall with the requester hammering new requests.
    @(negedge clk);
    drive_req(2'd0, 28'd5, 32'd0, 4'd0, 7'd4, 7'd6, 5'd11);
    @(negedge clk);
    @(negedge clk);
    check("stall_resp_v", 64'(bus.resp_v_o), 64'd1);
    check("stall_data0", 64'(bus.resp_data_o), 64'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      drive_req(2'($urandom_range(0, 3)), 28'($urandom_range(0, 63)), $urandom,
                4'hF, 7'($urandom), 7'($urandom), 5'($urandom));
      @(negedge clk);
      check("stall_hold_v", 64'(bus.resp_v_o), 64'd1);
      check("stall_hold_data", 64'(bus.resp_data_o), 64'hDEADBEEF);
      check("stall_hold_tag", 64'(bus.resp_reg_id_o), 64'd11);
      check("stall_hold_dst", 64'({bus.resp_dst_x_o, bus.resp_dst_y_o}), 64'({7'd4, 7'd6}));
      check("stall_no_ready", 64'(bus.req_ready_o), 64'd0);
    end
    drive_req(2'd0, 28'd7, 32'd0, 4'd0, 7'd1, 7'd1, 5'd9);
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    exp_req = exp_req + 32'd1;
    check("release_v_drop", 64'(bus.resp_v_o), 64'd0);
    check("release_ready", 64'(bus.req_ready_o), 64'd1);
    check("release_count", 64'(req_count), 64'(exp_req));
    @(negedge clk);
    bus.req_v_i = 1'b0;
    check("next_accept_1cyc", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    check("next_resp_v", 64'(bus.resp_v_o), 64'd1);
    check("next_resp_data", 64'(bus.resp_data_o), 64'h11BB33DD);
    check("next_resp_tag", 64'(bus.resp_reg_id_o), 64'd9);
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    exp_req = exp_req + 32'd1;
    check("next_count", 64'(req_count), 64'(exp_req));

    // Reset while a response is pending.
    ref_exec(2'd1, 28'd12, 32'hCAFEF00D, 4'hF, t, d);
    issue(2'd1, 28'd12, 32'hCAFEF00D, 4'hF, 7'd2, 7'd2, 5'd1, t, d);
    @(negedge clk);
    drive_req(2'd0, 28'd12, 32'd0, 4'd0, 7'd3, 7'd3, 5'd2);
    @(negedge clk);
    bus.req_v_i = 1'b0;
    @(negedge clk);
    check("pre_rst_resp_v", 64'(bus.resp_v_o), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_resp_v", 64'(bus.resp_v_o), 64'd0);
    check("async_rst_ready", 64'(bus.req_ready_o), 64'd0);
    check("async_rst_req_cnt", 64'(req_count), 64'd0);
    check("async_rst_err_cnt", 64'(err_count), 64'd0);
    exp_req = 0;
    exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    issue(2'd0, 28'd12, 32'd0, 4'd0, 7'd5, 7'd5, 5'd3, 2'd0, 32'hCAFEF00D);

    for (int i = 0; i < 64; i++) begin
      data = $urandom;
      ref_exec(2'd1, 28'(i), data, 4'hF, t, d);
      issue(2'd1, 28'(i), data, 4'hF, 7'($urandom), 7'($urandom), 5'($urandom), t, d);
    end

    for (int i = 0; i < 60; i++) begin
      op   = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 9) == 0) ? (28'($urandom) | 28'h40) : 28'($urandom_range(0, 63));
      data = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
      mask = 4'($urandom);
      ref_exec(op, addr, data, mask, t, d);
      issue(op, addr, data, mask, 7'($urandom), 7'($urandom), 5'($urandom), t, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
